// File: rtl/draw_pkg.sv
// Shared constants and types for the rectangle draw scheduler.
// Frame geometry, bus widths and the scheduler state encoding.
package draw_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 12;
  localparam int ROM_AW   = 16;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
  } rect_t;

endpackage

// File: rtl/rect_walker.sv
// Row-major pixel walker with ROM address counter, frame clip
// and one registered output stage.
module rect_walker
  import draw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ROM_AW-1:0] base,
  input  rect_t             rect,
  output logic              last,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              plot,
  output logic              valid,
  output logic [ROM_AW-1:0] rom_addr
);

  logic [X_W-1:0] i;
  logic [Y_W-1:0] j;
  logic [X_W:0]   xs;
  logic [Y_W:0]   ys;
  logic           on_screen;

  assign xs = {1'b0, rect.x0} + {1'b0, i};
  assign ys = {1'b0, rect.y0} + {1'b0, j};

  assign on_screen = (xs < 10'(SCREEN_W))
                  && (ys < 9'(SCREEN_H));

  assign last = (i == rect.w - 9'd1)
             && (j == rect.h - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i        <= '0;
      j        <= '0;
      rom_addr <= '0;
      x        <= '0;
      y        <= '0;
      plot     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= step;
      plot  <= step && on_screen;
      if (step) begin
        x <= xs[X_W-1:0];
        y <= ys[Y_W-1:0];
      end
      if (load) begin
        i        <= '0;
        j        <= '0;
        rom_addr <= base;
      end else if (step) begin
        // clipped pixels still advance the ROM address
        rom_addr <= rom_addr + 16'd1;
        if (i == rect.w - 9'd1) begin
          i <= '0;
          j <= j + 8'd1;
        end else begin
          i <= i + 9'd1;
        end
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin arbiter for rectangle fill/blit jobs feeding one
// shared pixel walker on the vga_adapter write port.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*9-1:0]     req_x,
  input  logic [NREQ*8-1:0]     req_y,
  input  logic [NREQ*9-1:0]     req_w,
  input  logic [NREQ*8-1:0]     req_h,
  input  logic [NREQ-1:0]       req_rom,
  input  logic [NREQ*16-1:0]    req_base,
  input  logic [NREQ*12-1:0]    req_fill,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [COLOUR_W-1:0]   rom_q,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  plot
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state;
  logic [GW-1:0]       last_q;
  logic [GW-1:0]       gsel;
  logic                gfound;
  rect_t               rect_d;
  rect_t               rect_q;
  logic [COLOUR_W-1:0] fill_q;
  logic                mode_rom;
  logic                empty_d;
  logic                empty_q;
  logic                load;
  logic                step;
  logic                wlast;
  logic                wvalid;

  // search upward from the previous winner so it ranks last
  always_comb begin
    gsel   = last_q;
    gfound = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gfound && req[(int'(last_q) + k) % NREQ]) begin
        gfound = 1'b1;
        gsel   = GW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    rect_d.x0 = req_x[int'(gsel)*X_W +: X_W];
    rect_d.y0 = req_y[int'(gsel)*Y_W +: Y_W];
    rect_d.w  = req_w[int'(gsel)*X_W +: X_W];
    rect_d.h  = req_h[int'(gsel)*Y_W +: Y_W];
  end

  assign empty_d = (rect_d.w == '0) || (rect_d.h == '0);
  assign load    = (state == S_IDLE) && gfound;
  assign step    = (state == S_WALK);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      last_q   <= GW'(NREQ - 1);
      ack      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      rect_q   <= '0;
      fill_q   <= '0;
      mode_rom <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      ack  <= '0;
      done <= '0;
      unique case (state)
        S_IDLE: begin
          if (gfound) begin
            rect_q   <= rect_d;
            fill_q   <= req_fill[int'(gsel)*COLOUR_W +: COLOUR_W];
            mode_rom <= req_rom[gsel];
            empty_q  <= empty_d;
            last_q   <= gsel;
            ack      <= NREQ'(1) << gsel;
            busy     <= 1'b1;
            state    <= empty_d ? S_FINISH : S_WALK;
          end
        end
        S_WALK: begin
          if (wlast) begin
            done  <= NREQ'(1) << last_q;
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          // a walked job already pulsed done with its last pixel
          if (empty_q) done <= NREQ'(1) << last_q;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  rect_walker u_walker (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .load     (load),
    .step     (step),
    .base     (req_base[int'(gsel)*ROM_AW +: ROM_AW]),
    .rect     (rect_q),
    .last     (wlast),
    .x        (x),
    .y        (y),
    .plot     (plot),
    .valid    (wvalid),
    .rom_addr (rom_addr)
  );

  assign colour = !wvalid ? '0
                : (mode_rom ? rom_q : fill_q);

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with a pixel scoreboard
// and a synchronous ROM model returning its own address.
module tb_draw_scheduler;

  localparam int NREQ = 4;

  logic              CLOCK_50 = 1'b0;
  logic              resetn   = 1'b0;
  logic [NREQ-1:0]   req      = '0;
  logic [NREQ*9-1:0] req_x    = '0;
  logic [NREQ*8-1:0] req_y    = '0;
  logic [NREQ*9-1:0] req_w    = '0;
  logic [NREQ*8-1:0] req_h    = '0;
  logic [NREQ-1:0]   req_rom  = '0;
  logic [NREQ*16-1:0] req_base = '0;
  logic [NREQ*12-1:0] req_fill = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [15:0]       rom_addr;
  logic [11:0]       rom_q;
  logic [8:0]        x;
  logic [7:0]        y;
  logic [11:0]       colour;
  logic              plot;

  draw_scheduler #(.NREQ(NREQ)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .req      (req),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_w    (req_w),
    .req_h    (req_h),
    .req_rom  (req_rom),
    .req_base (req_base),
    .req_fill (req_fill),
    .ack      (ack),
    .done     (done),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always_ff @(posedge CLOCK_50)
    rom_q <= rom_addr[11:0];

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    ntot++;
    assert (got === want) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic set_req(input int r, input bit on,
                         input int px, input int py,
                         input int pw, input int ph,
                         input bit rom, input int base,
                         input int fill);
    req_x[r*9 +: 9]     = 9'(px);
    req_y[r*8 +: 8]     = 8'(py);
    req_w[r*9 +: 9]     = 9'(pw);
    req_h[r*8 +: 8]     = 8'(ph);
    req_rom[r]          = rom;
    req_base[r*16 +: 16] = 16'(base);
    req_fill[r*12 +: 12] = 12'(fill);
    req[r]              = on;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = '0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic check_plot(input string name, input int t);
    exp_t e;
    if (plot) begin
      if (sb.size() == 0) begin
        chk({name, "_extra_plot"}, 32'(t), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk({name, "_plot_cyc"}, 32'(t), 32'(e.cyc));
        chk({name, "_x"}, 32'(x), 32'(e.x));
        chk({name, "_y"}, 32'(y), 32'(e.y));
        chk({name, "_colour"}, 32'(colour), 32'(e.col));
      end
    end
  endtask

  task automatic run_job(input string name, input int r,
                         input int px, input int py,
                         input int pw, input int ph,
                         input bit rom, input int base,
                         input int fill);
    int n;
    int t;
    int k;
    int xs;
    int ys;
    bit got_done;
    n = pw * ph;
    got_done = 1'b0;
    sb.delete();
    for (int j = 0; j < ph; j++) begin
      for (int i = 0; i < pw; i++) begin
        k  = j * pw + i;
        xs = px + i;
        ys = py + j;
        if (xs < 320 && ys < 240)
          sb.push_back('{2 + k, xs, ys,
                         rom ? ((base + k) & 'hFFF) : fill});
      end
    end
    set_req(r, 1'b1, px, py, pw, ph, rom, base, fill);
    @(negedge CLOCK_50);
    t = 1;
    while (!got_done && t <= n + 4) begin
      if (t == 1) begin
        chk({name, "_ack"}, 32'(ack), 32'(1 << r));
        chk({name, "_busy"}, 32'(busy), 32'd1);
        req[r] = 1'b0;
      end
      if (rom && t <= n)
        chk({name, "_rom_addr"}, 32'(rom_addr),
            32'((base + t - 1) & 'hFFFF));
      check_plot(name, t);
      if (done != '0) begin
        chk({name, "_done"}, 32'(done), 32'(1 << r));
        chk({name, "_done_cyc"}, 32'(t),
            32'((n == 0) ? 2 : n + 1));
        got_done = 1'b1;
      end
      @(negedge CLOCK_50);
      t++;
    end
    chk({name, "_got_done"}, 32'(got_done), 32'd1);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    sb.delete();
  endtask

  initial begin
    int nack;
    int prev_t;
    int exp_r;
    bit seen;

    repeat (2) @(negedge CLOCK_50);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_colour", 32'(colour), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    resetn = 1'b1;
    @(negedge CLOCK_50);

    run_job("fill", 0, 10, 20, 3, 2, 1'b0, 0, 'h844);
    run_job("rom", 1, 0, 0, 8, 8, 1'b1, 'h40, 0);
    run_job("clip", 2, 316, 238, 8, 4, 1'b0, 0, 'hABC);
    run_job("empty", 3, 5, 5, 0, 5, 1'b0, 0, 'h123);

    // round robin with all four requesters held high
    do_reset();
    sb.delete();
    for (int r = 0; r < NREQ; r++)
      set_req(r, 1'b1, 50 + 10 * r, 5, 1, 1, 1'b0, 0,
              'h100 * (r + 1));
    nack   = 0;
    prev_t = 0;
    for (int t = 1; t <= 25; t++) begin
      @(negedge CLOCK_50);
      if (ack != '0) begin
        exp_r = nack % NREQ;
        chk("rr_order", 32'(ack), 32'(1 << exp_r));
        chk("rr_spacing", 32'(t - prev_t),
            32'((nack == 0) ? 1 : 3));
        sb.push_back('{t + 1, 50 + 10 * exp_r, 5,
                       'h100 * (exp_r + 1)});
        prev_t = t;
        nack++;
        if (nack == 5) req = '0;
      end
      check_plot("rr", t);
    end
    chk("rr_acks", 32'(nack), 32'd5);
    chk("rr_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // reset in the middle of a 64-pixel job
    do_reset();
    set_req(0, 1'b1, 0, 0, 8, 8, 1'b0, 0, 'h0F0);
    set_req(1, 1'b1, 100, 100, 2, 2, 1'b0, 0, 'h00F);
    @(negedge CLOCK_50);
    chk("mid_ack", 32'(ack), 32'd1);
    repeat (5) @(negedge CLOCK_50);
    chk("mid_plot_before", 32'(plot), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_plot_rst", 32'(plot), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    chk("mid_ack_rst", 32'(ack), 32'd0);
    chk("mid_done_rst", 32'(done), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      @(negedge CLOCK_50);
      if (done != '0)
        chk("mid_no_done", 32'(done), 32'd0);
      if (ack != '0) begin
        chk("mid_regrant", 32'(ack), 32'd1);
        seen = 1'b1;
        req  = '0;
      end
    end
    chk("mid_regrant_seen", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int t = 0; t < 80 && !seen; t++) begin
      @(negedge CLOCK_50);
      if (done != '0) begin
        chk("mid_done", 32'(done), 32'd1);
        seen = 1'b1;
      end
    end
    chk("mid_done_seen", 32'(seen), 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
